// File: rtl/imem_access_ctrl.sv
// imem_access_ctrl
//   Sequencer and arbiter for the byte-wide instruction store. It shares one
//   single-port synchronous byte SRAM between the CPU fetch port (32-bit word
//   reads) and the program loader port (32-bit word writes). Each word access
//   is split into four byte beats, big-endian (byte at base+0 = bits [31:24]).
//
// Ports
//   clk, reset             clock (rising edge), synchronous active-high reset
//   fetch_req/fetch_addr   fetch request and byte address (word aligned internally)
//   fetch_ack/fetch_instr  one-cycle completion pulse, registered instruction word
//   load_req/load_addr     load request and byte address (word aligned internally)
//   load_data              word to write
//   load_ack               one-cycle pulse once all four bytes are written
//   busy                   high whenever the controller is not idle
//   mem_en/mem_we          SRAM beat enable and write enable
//   mem_addr/mem_wdata     SRAM byte address and write byte
//   mem_rdata              SRAM read byte, valid the cycle after a read beat
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no transaction; arbitrate fetch_req / load_req every edge
// FETCH  | read beats 0..3 on the SRAM, capturing bytes 0..2 behind them
// FWAIT  | last read byte arrives; assemble fetch_instr
// LOAD   | write beats 0..3 on the SRAM
// DONE   | ack pulse cycle, always back to IDLE

module imem_access_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_ack,
  output logic [31:0]       fetch_instr,
  input  logic              load_req,
  input  logic [31:0]       load_addr,
  input  logic [31:0]       load_data,
  output logic              load_ack,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_FWAIT = 3'd2,
    S_LOAD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state;
  logic [1:0]          beat;
  logic [ADDR_W-3:0]   word_idx;
  logic [23:0]         data_q;
  logic [23:0]         shift_q;
  logic                last_load;

  logic                grant_fetch;
  logic                grant_load;
  logic [1:0]          next_beat;
  logic [ADDR_W-3:0]   fetch_word;
  logic [ADDR_W-3:0]   load_word;
  logic                unused_addr_bits;

  // Tie goes to whichever requester was not granted last; last_load resets
  // to 0 (FETCH), so the first tie after reset is given to the loader.
  always_comb begin
    grant_fetch = fetch_req && (!load_req || last_load);
    grant_load  = load_req && (!fetch_req || !last_load);
  end

  assign next_beat  = beat + 2'd1;
  assign fetch_word = fetch_addr[ADDR_W-1:2];
  assign load_word  = load_addr[ADDR_W-1:2];

  assign unused_addr_bits = ^{fetch_addr[31:ADDR_W], fetch_addr[1:0],
                              load_addr[31:ADDR_W], load_addr[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      beat        <= 2'd0;
      word_idx    <= '0;
      data_q      <= '0;
      shift_q     <= '0;
      last_load   <= 1'b0;
      fetch_ack   <= 1'b0;
      load_ack    <= 1'b0;
      fetch_instr <= '0;
      busy        <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      fetch_ack <= 1'b0;
      load_ack  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_fetch) begin
            state     <= S_FETCH;
            last_load <= 1'b0;
            word_idx  <= fetch_word;
            beat      <= 2'd0;
            busy      <= 1'b1;
            mem_en    <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= {fetch_word, 2'b00};
          end else if (grant_load) begin
            state     <= S_LOAD;
            last_load <= 1'b1;
            word_idx  <= load_word;
            beat      <= 2'd0;
            busy      <= 1'b1;
            mem_en    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {load_word, 2'b00};
            mem_wdata <= load_data[31:24];
            data_q    <= load_data[23:0];
          end
        end
        S_FETCH: begin
          // Read data lags its beat by one cycle, so the byte arriving now
          // belongs to the previous beat.
          if (beat != 2'd0) begin
            shift_q <= {shift_q[15:0], mem_rdata};
          end
          if (beat == 2'd3) begin
            state  <= S_FWAIT;
            mem_en <= 1'b0;
          end else begin
            beat     <= next_beat;
            mem_addr <= {word_idx, next_beat};
          end
        end
        S_FWAIT: begin
          fetch_instr <= {shift_q, mem_rdata};
          fetch_ack   <= 1'b1;
          state       <= S_DONE;
        end
        S_LOAD: begin
          if (beat == 2'd3) begin
            state    <= S_DONE;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            load_ack <= 1'b1;
          end else begin
            beat      <= next_beat;
            mem_addr  <= {word_idx, next_beat};
            mem_wdata <= data_q[23:16];
            data_q    <= {data_q[15:0], 8'h00};
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          beat  <= 2'd0;
        end
        default: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Testbench for imem_access_ctrl: byte SRAM model, beat/ack monitor, a
// byte-level reference store, table vectors, hand-written corner sequences
// and a randomized load/fetch phase.
module tb_imem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ack;
  logic [31:0] fetch_instr;
  logic        load_req;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        load_ack;
  logic        busy;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  imem_access_ctrl #(.ADDR_W(10)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack), .fetch_instr(fetch_instr),
    .load_req(load_req), .load_addr(load_addr), .load_data(load_data),
    .load_ack(load_ack), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // SRAM model: synchronous byte store, read data one cycle after the beat
  logic [7:0] sram [0:1023];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata <= sram[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic [9:0] a; logic we; logic [7:0] wd; } beat_t;
  beat_t beats[$];
  int    fack_q[$];
  int    lack_q[$];

  always @(negedge clk) begin
    if (mem_en) beats.push_back('{cyc, mem_addr, mem_we, mem_wdata});
    if (fetch_ack) fack_q.push_back(cyc);
    if (load_ack)  lack_q.push_back(cyc);
  end

  // Reference store: bytes as the loader intends them, big-endian per word
  logic [7:0] ref_mem [0:1023];
  bit         ref_vld [0:1023];
  int         loaded_words[$];
  logic [31:0] last_fetched = 32'h0;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [9:0] base_of(input logic [31:0] a);
    return {a[9:2], 2'b00};
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [9:0] b;
    b = base_of(a);
    return {ref_mem[b], ref_mem[b+1], ref_mem[b+2], ref_mem[b+3]};
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] d);
    logic [9:0] b;
    b = base_of(a);
    for (int k = 0; k < 4; k++) begin
      ref_mem[b + k] = d[31 - 8*k -: 8];
      ref_vld[b + k] = 1'b1;
    end
    loaded_words.push_back(int'(b));
  endtask

  task automatic wait_ack(input bit want_load, output int at, output bit ok);
    ok = 0;
    at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (want_load ? load_ack : fetch_ack) begin
        ok = 1;
        at = cyc;
        break;
      end
    end
  endtask

  // One complete transaction from idle; returns at the negedge after the ack
  task automatic do_op(input bit is_load, input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] exp_word, output int ack_cyc);
    int g, start, n;
    bit ok;
    logic [9:0] b;
    b = base_of(addr);
    start = beats.size();
    if (is_load) begin load_req = 1; load_addr = addr; load_data = data; end
    else begin fetch_req = 1; fetch_addr = addr; end
    g = cyc + 1;
    wait_ack(is_load, ack_cyc, ok);
    load_req = 0;
    fetch_req = 0;
    check("ack_seen", 32'(ok), 32'd1);
    if (ok) check(is_load ? "load_latency" : "fetch_latency", 32'(ack_cyc - g + 1), is_load ? 32'd5 : 32'd6);
    if (is_load) check("instr_held", fetch_instr, last_fetched);
    else begin
      check("fetch_instr", fetch_instr, exp_word);
      last_fetched = exp_word;
    end
    n = beats.size() - start;
    check("beat_count", 32'(n), 32'd4);
    for (int k = 0; k < 4 && k < n; k++) begin
      check("beat_cycle", 32'(beats[start+k].c), 32'(g + k));
      check("beat_addr", 32'(beats[start+k].a), 32'(b + 10'(k)));
      check("beat_we", 32'(beats[start+k].we), 32'(is_load));
      if (is_load) check("beat_wdata", 32'(beats[start+k].wd), 32'(data[31 - 8*k -: 8]));
    end
    if (is_load) ref_store(addr, data);
    @(negedge clk);
    check("ack_pulse_low", 32'({fetch_ack, load_ack}), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
  endtask

  typedef struct { bit is_load; logic [31:0] addr; logic [31:0] data; logic [31:0] exp; } vec_t;
  vec_t vecs[7];

  initial begin
    int a1, a2, la1, la2, fa1, n0, nack, idx, mism;
    bit ok;
    logic [7:0] pre22, pre23;
    logic [31:0] addr, data;

    vecs[0] = '{1'b1, 32'h0000_03FC, 32'hDEAD_BEEF, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_07FC, 32'h0,         32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 32'h0000_0013, 32'h0,         32'h8C01_0004};
    vecs[3] = '{1'b0, 32'h0000_0010, 32'h0,         32'h8C01_0004};
    vecs[4] = '{1'b1, 32'h0000_0010, 32'h0123_4567, 32'h0};
    vecs[5] = '{1'b0, 32'hFFFF_FC12, 32'h0,         32'h0123_4567};
    vecs[6] = '{1'b0, 32'h0000_0014, 32'h0,         32'hCAFE_F00D};

    reset = 1; fetch_req = 0; load_req = 0;
    fetch_addr = 0; load_addr = 0; load_data = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_acks", 32'({fetch_ack, load_ack}), 32'd0);
    check("rst_mem_en_we", 32'({mem_en, mem_we}), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_fetch_instr", fetch_instr, 32'd0);
    reset = 0;
    @(negedge clk);

    // Tie right after reset: loader first, then fetch wins the next tie
    n0 = cyc;
    fetch_req = 1; fetch_addr = 32'h10;
    load_req = 1;  load_addr = 32'h10; load_data = 32'h8C01_0004;
    wait_ack(1'b1, la1, ok);
    check("tie1_load_ack", 32'(ok), 32'd1);
    check("tie1_load_first", 32'(la1 - n0), 32'd5);
    check("tie1_no_fetch_yet", 32'(fack_q.size()), 32'd0);
    ref_store(32'h10, 32'h8C01_0004);
    load_req = 0;
    @(negedge clk);
    load_req = 1; load_addr = 32'h14; load_data = 32'hCAFE_F00D;
    wait_ack(1'b0, fa1, ok);
    fetch_req = 0;
    check("tie2_fetch_ack", 32'(ok), 32'd1);
    check("tie2_fetch_wins", 32'(fa1 - la1), 32'd7);
    check("tie2_instr", fetch_instr, 32'h8C01_0004);
    last_fetched = 32'h8C01_0004;
    wait_ack(1'b1, la2, ok);
    load_req = 0;
    check("tie3_load_ack", 32'(ok), 32'd1);
    check("tie3_load_after", 32'(la2 - fa1), 32'd6);
    ref_store(32'h14, 32'hCAFE_F00D);
    @(negedge clk);
    for (int k = 0; k < 4; k++) check("sram_0x10", 32'(sram[10'h10 + 10'(k)]), 32'(ref_mem[10'h10 + 10'(k)]));
    check("sram_0x10_literal", {sram[10'h10], sram[10'h11], sram[10'h12], sram[10'h13]}, 32'h8C01_0004);

    // Table vectors
    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].is_load, vecs[i].addr, vecs[i].data, vecs[i].exp, a1);
      if (!vecs[i].is_load) check("vec_model", vecs[i].exp, ref_word(vecs[i].addr));
    end

    // Back-to-back throughput
    do_op(1'b0, 32'h3FC, 0, 32'hDEAD_BEEF, a1);
    do_op(1'b0, 32'h10, 0, 32'h0123_4567, a2);
    check("b2b_fetch_spacing", 32'(a2 - a1), 32'd7);
    do_op(1'b1, 32'h100, 32'hA5A5_0001, 0, a1);
    do_op(1'b1, 32'h104, 32'h5A5A_0002, 0, a2);
    check("b2b_load_spacing", 32'(a2 - a1), 32'd6);

    // Reset in the middle of a load: third beat never issued
    pre22 = sram[10'h22];
    pre23 = sram[10'h23];
    nack = lack_q.size();
    load_req = 1; load_addr = 32'h20; load_data = 32'h1122_3344;
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_mem_en", 32'(mem_en), 32'd0);
    check("midrst_instr_clear", fetch_instr, 32'd0);
    reset = 0; load_req = 0;
    last_fetched = 32'h0;
    repeat (8) @(negedge clk);
    check("midrst_no_ack", 32'(lack_q.size()), 32'(nack));
    check("midrst_0x20", 32'(sram[10'h20]), 32'h11);
    check("midrst_0x21", 32'(sram[10'h21]), 32'h22);
    check("midrst_0x22", 32'(sram[10'h22]), 32'(pre22));
    check("midrst_0x23", 32'(sram[10'h23]), 32'(pre23));
    ref_mem[10'h20] = 8'h11; ref_vld[10'h20] = 1'b1;
    ref_mem[10'h21] = 8'h22; ref_vld[10'h21] = 1'b1;

    // Randomized traffic against the reference store
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        addr = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(0, 3));
        data = $urandom;
        do_op(1'b1, addr, data, 0, a1);
      end else begin
        idx = loaded_words[$urandom_range(0, loaded_words.size() - 1)];
        addr = ($urandom & 32'hFFFF_FC00) | 32'(idx) | 32'($urandom_range(0, 3));
        do_op(1'b0, addr, 0, ref_word(addr), a1);
      end
    end

    mism = 0;
    for (int j = 0; j < 1024; j++)
      if (ref_vld[j] && sram[j] !== ref_mem[j]) mism++;
    check("sram_vs_model", 32'(mism), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
